// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, the NOP instruction pattern and register-address constants.
package pipeline_ctrl_pkg;

  // Sequencer states; the encoding is visible on the ctrl_state debug port.
  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_RUN     = 2'd1,
    ST_MD_WAIT = 2'd2
  } ctrl_state_e;

  // Instruction word the datapath muxes into a latch when its bubble bit is high.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Default register-address width.
  localparam int REG_AW_DFLT = 5;

  // Register 0 is hardwired to zero, so writing it never creates a hazard.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags when the F/D instruction reads
// the register that the load currently in D/X is about to write.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rt,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic              dx_is_load,
  output logic              load_use
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  // Compare both source operands against the load destination.
  always_comb begin
    load_use = dx_is_load && (dx_rd != ZERO_ADDR) &&
               ((fd_rs == dx_rd) || (fd_uses_rt && (fd_rt == dx_rd)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: drives latch write enables and bubble selects,
// resolving load-use stalls, taken-branch flushes and mult/div freezes.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
// All control outputs are combinational from state and inputs; only
// ctrl_state and md_error are registered.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DFLT,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rt,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic              dx_is_load,
  input  logic              dx_is_md,
  input  logic              branch_taken,
  input  logic              md_ready,
  output logic              pc_wren,
  output logic              fd_wren,
  output logic              dx_wren,
  output logic              xm_wren,
  output logic              mw_wren,
  output logic              fd_bubble,
  output logic              dx_bubble,
  output logic              xm_bubble,
  output logic              md_start,
  output logic              md_error,
  output logic [1:0]        ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          md_error_q, md_error_d;
  logic          load_use;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rt (fd_uses_rt),
    .dx_rd      (dx_rd),
    .dx_is_load (dx_is_load),
    .load_use   (load_use)
  );

  // State, timeout counter and sticky error register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      md_cnt_q   <= '0;
      md_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      md_error_q <= md_error_d;
    end
  end

  // Next-state and output decode; reset forces every latch closed and bubbled.
  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    md_error_d = md_error_q;
    pc_wren    = 1'b0;
    fd_wren    = 1'b0;
    dx_wren    = 1'b0;
    xm_wren    = 1'b0;
    mw_wren    = 1'b0;
    fd_bubble  = 1'b0;
    dx_bubble  = 1'b0;
    xm_bubble  = 1'b0;
    md_start   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Flush NOPs through every latch while holding the PC.
        {fd_wren, dx_wren, xm_wren, mw_wren} = 4'b1111;
        {fd_bubble, dx_bubble, xm_bubble}     = 3'b111;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          // Squash the two younger instructions; the branch itself advances.
          {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren} = 5'b11111;
          {fd_bubble, dx_bubble}                         = 2'b11;
        end else if (dx_is_md) begin
          md_start  = 1'b1;
          xm_wren   = 1'b1;
          mw_wren   = 1'b1;
          xm_bubble = 1'b1;
          md_cnt_d  = '0;
          state_d   = ST_MD_WAIT;
        end else if (load_use) begin
          dx_wren   = 1'b1;
          xm_wren   = 1'b1;
          mw_wren   = 1'b1;
          dx_bubble = 1'b1;
        end else begin
          {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren} = 5'b11111;
        end
      end
      ST_MD_WAIT: begin
        md_cnt_d = md_cnt_q + CW'(1);
        if (md_ready || (md_cnt_q == CNT_LAST)) begin
          // Result available (or forced out): the md instruction advances.
          {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren} = 5'b11111;
          state_d = ST_RUN;
          if (!md_ready) md_error_d = 1'b1;
        end else begin
          xm_wren   = 1'b1;
          mw_wren   = 1'b1;
          xm_bubble = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    if (!reset_n) begin
      {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren} = 5'b00000;
      {fd_bubble, dx_bubble, xm_bubble}             = 3'b111;
      md_start = 1'b0;
    end
  end

  assign ctrl_state = state_q;
  assign md_error   = md_error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Event counters: PC-hold cycles outside CLEAR, and taken-branch flushes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != ST_CLEAR) && !pc_wren) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == ST_RUN) && branch_taken) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MD_TIMEOUT overridden to 8).
// Covers HAZARD_PERF_CNT_EN counters when that macro is defined.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;

  // Control vector layout: {pc,fd,dx,xm,mw wren, fd,dx,xm bubble, md_start}
  localparam logic [9:0] V_RESET = 10'b00000_111_0;
  localparam logic [9:0] V_CLEAR = 10'b01111_111_0;
  localparam logic [9:0] V_NORM  = 10'b11111_000_0;
  localparam logic [9:0] V_LU    = 10'b00111_010_0;
  localparam logic [9:0] V_BR    = 10'b11111_110_0;
  localparam logic [9:0] V_MDS   = 10'b00011_001_1;
  localparam logic [9:0] V_MDW   = 10'b00011_001_0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [AW-1:0] fd_rs, fd_rt, dx_rd;
  logic fd_uses_rt, dx_is_load, dx_is_md, branch_taken, md_ready;
  logic pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
  logic fd_bubble, dx_bubble, xm_bubble, md_start, md_error;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  pipeline_hazard_ctrl #(.REG_AW(AW), .MD_TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
    .dx_rd(dx_rd), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_wren(pc_wren), .fd_wren(fd_wren), .dx_wren(dx_wren),
    .xm_wren(xm_wren), .mw_wren(mw_wren),
    .fd_bubble(fd_bubble), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
    .md_start(md_start), .md_error(md_error), .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  wire [9:0] outs = {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren,
                     fd_bubble, dx_bubble, xm_bubble, md_start};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic urt, input logic md,
                       input logic br, input logic rdy);
    dx_is_load = ld; dx_rd = rd; fd_rs = rs; fd_rt = rt; fd_uses_rt = urt;
    dx_is_md = md; branch_taken = br; md_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset_release();
    reset_n = 1'b1;
    idle();
    check("clear_outs", 32'(outs), 32'(V_CLEAR));
    check("clear_state", 32'(ctrl_state), 32'd0);
    tick();
    idle();
    check("run_outs", 32'(outs), 32'(V_NORM));
    check("run_state", 32'(ctrl_state), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    idle();
    tick();
    tick();
    check("reset_outs", 32'(outs), 32'(V_RESET));
    check("reset_state", 32'(ctrl_state), 32'd0);
    check("reset_err", 32'(md_error), 32'd0);
    do_reset_release();

    // Load-use on rs, then the load is gone.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_rs", 32'(outs), 32'(V_LU));
    tick();
    idle();
    check("lu_after", 32'(outs), 32'(V_NORM));
    check("lu_state", 32'(ctrl_state), 32'd1);
    // Load-use through rt only when rt is actually read.
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rt", 32'(outs), 32'(V_LU));
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_rt_unused", 32'(outs), 32'(V_NORM));
    // Register 0 never stalls.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_r0", 32'(outs), 32'(V_NORM));
    // Non-load with matching register does not stall.
    drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nonload", 32'(outs), 32'(V_NORM));
    // Branch beats a simultaneous load-use.
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("br_over_lu", 32'(outs), 32'(V_BR));
    // Stray md_ready in RUN is ignored.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rdy_in_run", 32'(outs), 32'(V_NORM));
    tick();
    idle();
    check("rdy_run_state", 32'(ctrl_state), 32'd1);

    // Mult: start pulse, 4 frozen cycles, md_ready on the 5th.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("md_start", 32'(outs), 32'(V_MDS));
    tick();
    for (int i = 0; i < 4; i++) begin
      // md flag stays high and a stray branch is present: both ignored.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (i == 1), 1'b0);
      check($sformatf("md_wait%0d", i), 32'(outs), 32'(V_MDW));
      check($sformatf("md_wait_st%0d", i), 32'(ctrl_state), 32'd2);
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("md_ready", 32'(outs), 32'(V_NORM));
    tick();
    idle();
    check("md_back_state", 32'(ctrl_state), 32'd1);
    check("md_no_err", 32'(md_error), 32'd0);

    // Timeout: 8 MD_WAIT cycles, the 8th exits with md_error set.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("to_start", 32'(outs), 32'(V_MDS));
    tick();
    idle();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("to_wait%0d", i), 32'(outs), 32'(V_MDW));
      tick();
      idle();
    end
    check("to_exit", 32'(outs), 32'(V_NORM));
    check("to_exit_st", 32'(ctrl_state), 32'd2);
    check("to_err_pre", 32'(md_error), 32'd0);
    tick();
    idle();
    check("to_state", 32'(ctrl_state), 32'd1);
    check("to_err", 32'(md_error), 32'd1);
    tick();
    tick();
    check("to_err_sticky", 32'(md_error), 32'd1);

    // Reset asserted in the middle of MD_WAIT.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check("mid_wait_st", 32'(ctrl_state), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(ctrl_state), 32'd0);
    check("mid_rst_err", 32'(md_error), 32'd0);
    check("mid_rst_outs", 32'(outs), 32'(V_RESET));
`ifdef HAZARD_PERF_CNT_EN
    check("mid_rst_stall", stall_count, 32'd0);
    check("mid_rst_flush", flush_count, 32'd0);
`endif
    tick();
    do_reset_release();

`ifdef HAZARD_PERF_CNT_EN
    // Three load-use stalls interleaved with two branch flushes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i < 2) begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
      end
    end
    idle();
    tick();
    check("perf_stall", stall_count, 32'd3);
    check("perf_flush", flush_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
